bsg_chip_mc_fwd_link_arbiter: RTL and testbench

BSG_CHIP_MC_FWD_LINK_ARBITER -- requirements
Module: bsg_chip_mc_fwd_link_arbiter

---
 rtl/bsg_chip_mc_fwd_link_arbiter.sv | 86 ++++++++
 tb/tb_bsg_chip_mc_fwd_link_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_chip_mc_fwd_link_arbiter.sv
// Credit-based round-robin arbiter that merges several manycore forward-packet
// requesters onto a single registered host link.
module bsg_chip_mc_fwd_link_arbiter #(
    parameter int num_in_p  = 4,
    parameter int width_p   = 128,
    parameter int credits_p = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [num_in_p-1:0]           v_i,
    input  logic [num_in_p*width_p-1:0]   data_i,
    output logic [num_in_p-1:0]           yumi_o,
    output logic                          v_o,
    output logic [width_p-1:0]            data_o,
    input  logic                          token_i,
    output logic [7:0]                    credits_o,
    output logic                          err_o
);

    localparam int                ptr_w       = $clog2(num_in_p);
    localparam logic [7:0]        credits_max = 8'(credits_p);
    localparam logic [ptr_w-1:0]  last_idx    = ptr_w'(num_in_p - 1);

    logic [ptr_w-1:0]   ptr_r;
    logic [ptr_w-1:0]   grant_idx;
    logic               found;
    logic               send;
    logic [width_p-1:0] grant_data;
    int unsigned        scan_idx;

    // Scan from the priority pointer with wrap-around; first set valid wins.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < num_in_p; k++) begin
            scan_idx = 32'(ptr_r) + k;
            if (scan_idx >= num_in_p) begin
                scan_idx = scan_idx - num_in_p;
            end
            if (!found && v_i[scan_idx[ptr_w-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan_idx[ptr_w-1:0];
            end
        end
    end

    // Credits are checked against the registered count only, so a token in
    // the same cycle cannot enable a send.
    assign send       = !reset_i && (credits_o != 8'd0) && found;
    assign grant_data = data_i[grant_idx*width_p +: width_p];

    always_comb begin
        yumi_o = '0;
        if (send) begin
            yumi_o[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_o <= credits_max;
            ptr_r     <= '0;
            v_o       <= 1'b0;
            data_o    <= '0;
            err_o     <= 1'b0;
        end else begin
            v_o <= send;
            if (send) begin
                data_o <= grant_data;
                ptr_r  <= (grant_idx == last_idx) ? '0 : grant_idx + 1'b1;
            end
            if (send && !token_i) begin
                credits_o <= credits_o - 8'd1;
            end else if (!send && token_i) begin
                // A token with a full counter is a protocol error: saturate and flag.
                if (credits_o == credits_max) begin
                    err_o <= 1'b1;
                end else begin
                    credits_o <= credits_o + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_chip_mc_fwd_link_arbiter.sv
// Scoreboard bench: driver predicts grants/credits from the arbitration rules,
// a separate monitor checks every link output against the expected-packet queue.
module tb_bsg_chip_mc_fwd_link_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int C = 8;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           token_i = 1'b0;
    logic [N-1:0]   v_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic [N-1:0]   yumi_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic [7:0]     credits_o;
    logic           err_o;

    always #5 clk = ~clk;

    bsg_chip_mc_fwd_link_arbiter #(
        .num_in_p (N),
        .width_p  (W),
        .credits_p(C)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .v_i      (v_i),
        .data_i   (data_i),
        .yumi_o   (yumi_o),
        .v_o      (v_o),
        .data_o   (data_o),
        .token_i  (token_i),
        .credits_o(credits_o),
        .err_o    (err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state
    int           m_credits = C;
    int           m_ptr = 0;
    bit           m_err = 1'b0;
    bit           pending[N];
    logic [W-1:0] pdata[N];
    int           grant_log[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_data = '0;

    // Monitor: every link cycle must match the head of the expected queue.
    always @(posedge clk) begin
        #1;
        if (reset_i) begin
            check("reset_link", {31'd0, v_o, data_o}, 64'd0);
            last_data = '0;
        end else begin
            check("v_o", 64'(v_o), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                last_data = exp_q.pop_front();
                check("data_o", 64'(data_o), 64'(last_data));
            end else begin
                check("data_hold", 64'(data_o), 64'(last_data));
            end
        end
    end

    task automatic cycle(input bit rst, input logic [N-1:0] vreq, input bit tok);
        int g;
        logic [N-1:0] ey;
        @(negedge clk);
        check("credits_o", 64'(credits_o), 64'(m_credits));
        check("err_o", 64'(err_o), 64'(m_err));
        for (int i = 0; i < N; i++) begin
            if (vreq[i] && !pending[i]) begin
                pending[i] = 1'b1;
                pdata[i]   = $urandom;
            end
            v_i[i]         = pending[i];
            data_i[i*W +: W] = pdata[i];
        end
        reset_i = rst;
        token_i = tok;
        #1;
        g = -1;
        if (!rst && m_credits > 0) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pending[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        ey = '0;
        if (g >= 0) ey[g] = 1'b1;
        check("yumi_o", 64'(yumi_o), 64'(ey));
        if (g >= 0) begin
            exp_q.push_back(pdata[g]);
            pending[g] = 1'b0;
            grant_log.push_back(g);
            m_ptr = (g + 1) % N;
        end
        if (rst) begin
            m_credits = C;
            m_ptr     = 0;
            m_err     = 1'b0;
        end else if (g >= 0 && !tok) begin
            m_credits--;
        end else if (g < 0 && tok) begin
            if (m_credits == C) m_err = 1'b1;
            else m_credits++;
        end
    endtask

    task automatic clear_requests();
        for (int i = 0; i < N; i++) pending[i] = 1'b0;
    endtask

    initial begin
        int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        bit rst;
        bit tok;
        logic [N-1:0] vreq;

        for (int i = 0; i < N; i++) begin
            pending[i] = 1'b0;
            pdata[i]   = '0;
        end

        // All requesters valid, no tokens: rotate through every index until credits run out.
        repeat (2) cycle(1'b1, '0, 1'b0);
        grant_log.delete();
        repeat (10) cycle(1'b0, 4'hF, 1'b0);
        check("rr_count", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("rr_order", 64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(exp_order[i]));
        end

        // One token at zero credits buys exactly one more grant.
        cycle(1'b0, 4'hF, 1'b1);
        grant_log.delete();
        repeat (2) cycle(1'b0, 4'hF, 1'b0);
        check("token_regrant", 64'(grant_log.size()), 64'd1);

        // Spurious token with a full counter sets a sticky error.
        clear_requests();
        repeat (2) cycle(1'b1, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);

        // Pointer at 2 with requesters 1 and 3: grants 3, 1 (wrap), 3.
        cycle(1'b0, 4'b0010, 1'b0);
        grant_log.delete();
        repeat (3) cycle(1'b0, 4'b1010, 1'b0);
        check("wrap_count", 64'(grant_log.size()), 64'd3);
        check("wrap_g0", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd3);
        check("wrap_g1", 64'((grant_log.size() > 1) ? grant_log[1] : -1), 64'd1);
        check("wrap_g2", 64'((grant_log.size() > 2) ? grant_log[2] : -1), 64'd3);

        // Mid-stream reset with requests pending; first grant afterwards is the lowest index.
        cycle(1'b0, 4'hF, 1'b0);
        cycle(1'b0, 4'hF, 1'b0);
        clear_requests();
        repeat (2) cycle(1'b1, 4'b0110, 1'b0);
        grant_log.delete();
        cycle(1'b0, '0, 1'b0);
        check("post_reset_grant", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd1);

        // Send and token together leave the count unchanged.
        repeat (2) cycle(1'b0, 4'hF, 1'b0);
        cycle(1'b0, 4'hF, 1'b1);
        cycle(1'b0, 4'hF, 1'b0);

        // Randomized traffic with occasional spurious tokens and resets.
        clear_requests();
        repeat (2) cycle(1'b1, '0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            vreq = N'($urandom & $urandom);
            tok  = (m_credits < C) ? ($urandom_range(99) < 45) : ($urandom_range(99) < 3);
            rst  = ($urandom_range(99) < 2);
            cycle(rst, vreq, tok);
        end
        repeat (3) cycle(1'b0, '0, 1'b0);
        @(posedge clk);
        #2;
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
